// File: rtl/gpu_pkg.sv
// Shared encodings for the core FSM state and the register-write source select.
// Used by every block that decodes core_state or dec_reg_input_mux.
package gpu_pkg;

  typedef enum logic [2:0] {
    REQUEST = 3'b011,
    UPDATE  = 3'b110
  } core_state_e;

  typedef enum logic [1:0] {
    ARITHMETIC = 2'b00,
    CONSTANT   = 2'b01,
    MEMORY     = 2'b10,
    NONE       = 2'b11
  } reg_input_mux_e;

endpackage

// File: rtl/thread_regfile.sv
// One thread's register file: GP storage plus read-only block ID / block dim / thread ID.
// Reads register in 1 cycle during REQUEST; writes land on the UPDATE edge. THREAD_REGFILE_ZERO_REG_EN hardwires r0 to 0.
module thread_regfile #(
  parameter  int DATA_BITS = 8,
  parameter  int NUM_REGS  = 16,
  parameter  int THREAD_ID = 0,
  localparam int ADDR_BITS = $clog2(NUM_REGS)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 active_i,
  input  logic [2:0]           core_state_i,
  input  logic                 write_en_i,
  input  logic [1:0]           input_mux_i,
  input  logic [ADDR_BITS-1:0] rs_addr_i,
  input  logic [ADDR_BITS-1:0] rt_addr_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  input  logic [DATA_BITS-1:0] imm_i,
  input  logic [DATA_BITS-1:0] alu_out_i,
  input  logic [DATA_BITS-1:0] lsu_out_i,
  input  logic [DATA_BITS-1:0] block_id_i,
  input  logic [DATA_BITS-1:0] block_dim_i,
  output logic [DATA_BITS-1:0] rs_o,
  output logic [DATA_BITS-1:0] rt_o
);
  import gpu_pkg::*;

  localparam int                   GP_REGS = NUM_REGS - 3;
  localparam logic [ADDR_BITS-1:0] BID_IDX = ADDR_BITS'(NUM_REGS - 3);
  localparam logic [ADDR_BITS-1:0] DIM_IDX = ADDR_BITS'(NUM_REGS - 2);

  logic [DATA_BITS-1:0] regs_q [GP_REGS];
  logic [DATA_BITS-1:0] rs_q, rs_d;
  logic [DATA_BITS-1:0] rt_q, rt_d;
  logic [DATA_BITS-1:0] wr_dat;
  logic                 wr_vld;
  logic                 rd_fire;

  // The three top indices are specials; everything below BID_IDX is GP storage.
  function automatic logic [DATA_BITS-1:0] read_reg(input logic [ADDR_BITS-1:0] a);
    if (a == BID_IDX)      return block_id_i;
    else if (a == DIM_IDX) return block_dim_i;
    else if (a > DIM_IDX)  return DATA_BITS'(THREAD_ID);
`ifdef THREAD_REGFILE_ZERO_REG_EN
    else if (a == '0)      return '0;
`endif
    else                   return regs_q[a];
  endfunction

  always_comb begin
    rd_fire = enable_i && active_i && (core_state_i == REQUEST);
    rs_d    = rd_fire ? read_reg(rs_addr_i) : rs_q;
    rt_d    = rd_fire ? read_reg(rt_addr_i) : rt_q;

    wr_dat = alu_out_i;
    wr_vld = 1'b0;
    case (input_mux_i)
      ARITHMETIC: begin wr_dat = alu_out_i; wr_vld = 1'b1; end
      CONSTANT:   begin wr_dat = imm_i;     wr_vld = 1'b1; end
      MEMORY:     begin wr_dat = lsu_out_i; wr_vld = 1'b1; end
      default:    wr_vld = 1'b0;
    endcase
    if (!(enable_i && active_i && (core_state_i == UPDATE) && write_en_i && (rd_addr_i < BID_IDX)))
      wr_vld = 1'b0;
`ifdef THREAD_REGFILE_ZERO_REG_EN
    if (rd_addr_i == '0) wr_vld = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < GP_REGS; i++) regs_q[i] <= '0;
      rs_q <= '0;
      rt_q <= '0;
    end else begin
      rs_q <= rs_d;
      rt_q <= rt_d;
      if (wr_vld) regs_q[rd_addr_i] <= wr_dat;
    end
  end

  assign rs_o = rs_q;
  assign rt_o = rt_q;

endmodule

// File: rtl/thread_regfile_bank.sv
// Bank of NUM_THREADS register files sharing one decoder; holds the dispatch latch (block ID, mask popcount).
// Read data is registered (1 cycle); no backpressure. THREAD_REGFILE_ZERO_REG_EN hardwires r0 to 0.
module thread_regfile_bank #(
  parameter  int NUM_THREADS = 4,
  parameter  int DATA_BITS   = 8,
  parameter  int NUM_REGS    = 16,
  localparam int ADDR_BITS   = $clog2(NUM_REGS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  dispatch,
  input  logic [DATA_BITS-1:0]                  block_id,
  input  logic [NUM_THREADS-1:0]                thread_mask,
  input  logic [2:0]                            core_state,
  input  logic                                  dec_reg_write_en,
  input  logic [1:0]                            dec_reg_input_mux,
  input  logic [ADDR_BITS-1:0]                  dec_rs_address,
  input  logic [ADDR_BITS-1:0]                  dec_rt_address,
  input  logic [ADDR_BITS-1:0]                  dec_rd_address,
  input  logic [DATA_BITS-1:0]                  dec_imm,
  input  logic [NUM_THREADS-1:0][DATA_BITS-1:0] alu_out,
  input  logic [NUM_THREADS-1:0][DATA_BITS-1:0] lsu_out,
  output logic [NUM_THREADS-1:0][DATA_BITS-1:0] rs,
  output logic [NUM_THREADS-1:0][DATA_BITS-1:0] rt,
  output logic [DATA_BITS-1:0]                  block_dim
);
  import gpu_pkg::*;

  logic [DATA_BITS-1:0] block_id_q;
  logic [DATA_BITS-1:0] block_dim_q;
  logic [DATA_BITS-1:0] block_dim_d;

  always_comb begin
    block_dim_d = '0;
    for (int t = 0; t < NUM_THREADS; t++) block_dim_d = block_dim_d + DATA_BITS'(thread_mask[t]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      block_id_q  <= '0;
      block_dim_q <= DATA_BITS'(NUM_THREADS);
    end else if (enable && dispatch) begin
      block_id_q  <= block_id;
      block_dim_q <= block_dim_d;
    end
  end

  assign block_dim = block_dim_q;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
    thread_regfile #(
      .DATA_BITS(DATA_BITS),
      .NUM_REGS (NUM_REGS),
      .THREAD_ID(t)
    ) u_rf (
      .clk_i       (clk),
      .reset_i     (reset),
      .enable_i    (enable),
      .active_i    (thread_mask[t]),
      .core_state_i(core_state),
      .write_en_i  (dec_reg_write_en),
      .input_mux_i (dec_reg_input_mux),
      .rs_addr_i   (dec_rs_address),
      .rt_addr_i   (dec_rt_address),
      .rd_addr_i   (dec_rd_address),
      .imm_i       (dec_imm),
      .alu_out_i   (alu_out[t]),
      .lsu_out_i   (lsu_out[t]),
      .block_id_i  (block_id_q),
      .block_dim_i (block_dim_q),
      .rs_o        (rs[t]),
      .rt_o        (rt[t])
    );
  end

endmodule

// File: tb/tb_thread_regfile_bank.sv
// Drives a default bank (4x8b, 16 regs) and a wide bank (8x16b, 32 regs) with the same directed steps.
module tb_thread_regfile_bank;
  localparam logic [2:0] REQ = 3'b011, UPD = 3'b110, IDL = 3'b000;
`ifdef THREAD_REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif
  localparam int NT [2] = '{4, 8};
  localparam int NR [2] = '{16, 32};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, enable, dispatch, we;
  logic [2:0] core_state;
  logic [1:0] mux;

  logic [7:0]       a_bid, a_imm, a_dim;
  logic [3:0]       a_mask, a_rsa, a_rta, a_rda;
  logic [3:0][7:0]  a_alu, a_lsu, a_rs, a_rt;
  logic [15:0]      b_bid, b_imm, b_dim;
  logic [7:0]       b_mask;
  logic [4:0]       b_rsa, b_rta, b_rda;
  logic [7:0][15:0] b_alu, b_lsu, b_rs, b_rt;

  thread_regfile_bank #(.NUM_THREADS(4), .DATA_BITS(8), .NUM_REGS(16)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .dispatch(dispatch), .block_id(a_bid),
    .thread_mask(a_mask), .core_state(core_state), .dec_reg_write_en(we), .dec_reg_input_mux(mux),
    .dec_rs_address(a_rsa), .dec_rt_address(a_rta), .dec_rd_address(a_rda), .dec_imm(a_imm),
    .alu_out(a_alu), .lsu_out(a_lsu), .rs(a_rs), .rt(a_rt), .block_dim(a_dim)
  );

  thread_regfile_bank #(.NUM_THREADS(8), .DATA_BITS(16), .NUM_REGS(32)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .dispatch(dispatch), .block_id(b_bid),
    .thread_mask(b_mask), .core_state(core_state), .dec_reg_write_en(we), .dec_reg_input_mux(mux),
    .dec_rs_address(b_rsa), .dec_rt_address(b_rta), .dec_rd_address(b_rda), .dec_imm(b_imm),
    .alu_out(b_alu), .lsu_out(b_lsu), .rs(b_rs), .rt(b_rt), .block_dim(b_dim)
  );

  typedef struct {
    string       tag;
    int          d;
    int          t;
    logic [15:0] rs;
    logic [15:0] rt;
    logic [15:0] dim;
  } exp_t;

  exp_t        sb [$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] m_gp  [2][8][32];
  logic [15:0] m_rs  [2][8];
  logic [15:0] m_rt  [2][8];
  logic [15:0] m_bid [2];
  logic [15:0] m_dim [2];

  // Negative addresses count down from the top: -3 block ID, -2 block dim, -1 thread ID.
  function automatic int ad(input int d, input int a);
    return (a < 0) ? NR[d] + a : a;
  endfunction

  function automatic logic [15:0] dw(input int d, input logic [15:0] v);
    return (d == 0) ? {8'h00, v[7:0]} : v;
  endfunction

  function automatic logic [15:0] model_read(input int d, input int t, input int a);
    if (a == NR[d] - 3) return m_bid[d];
    if (a == NR[d] - 2) return m_dim[d];
    if (a == NR[d] - 1) return 16'(t);
    if (ZERO && a == 0) return 16'h0000;
    return m_gp[d][t][a];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input string tag, input bit rst, input bit en, input bit disp,
                       input logic [15:0] bid, input logic [7:0] mask, input logic [2:0] st,
                       input bit wen, input logic [1:0] mx, input int rsa, input int rta,
                       input int rda, input logic [15:0] imm);
    exp_t e;
    reset = rst; enable = en; dispatch = disp; core_state = st; we = wen; mux = mx;
    a_bid = bid[7:0]; b_bid = bid; a_imm = imm[7:0]; b_imm = imm;
    a_mask = mask[3:0]; b_mask = mask;
    a_rsa = 4'(ad(0, rsa)); a_rta = 4'(ad(0, rta)); a_rda = 4'(ad(0, rda));
    b_rsa = 5'(ad(1, rsa)); b_rta = 5'(ad(1, rta)); b_rda = 5'(ad(1, rda));
    for (int d = 0; d < 2; d++) begin
      int rdi = ad(d, rda);
      if (rst) begin
        for (int t = 0; t < 8; t++) begin
          for (int r = 0; r < 32; r++) m_gp[d][t][r] = 16'h0000;
          m_rs[d][t] = 16'h0000;
          m_rt[d][t] = 16'h0000;
        end
        m_bid[d] = 16'h0000;
        m_dim[d] = 16'(NT[d]);
      end else if (en) begin
        for (int t = 0; t < NT[d]; t++) begin
          if (mask[t]) begin
            if (st == REQ) begin
              m_rs[d][t] = model_read(d, t, ad(d, rsa));
              m_rt[d][t] = model_read(d, t, ad(d, rta));
            end
            if (st == UPD && wen && rdi < NR[d] - 3 && mx != 2'b11 && !(ZERO && rdi == 0))
              m_gp[d][t][rdi] = dw(d, (mx == 2'b00) ? 16'(16'hA0 + t) :
                                      (mx == 2'b01) ? imm : 16'(16'h10 + t));
          end
        end
        if (disp) begin
          int cnt = 0;
          for (int t = 0; t < NT[d]; t++) cnt += int'(mask[t]);
          m_bid[d] = dw(d, bid);
          m_dim[d] = 16'(cnt);
        end
      end
      for (int t = 0; t < NT[d]; t++) begin
        e.tag = tag; e.d = d; e.t = t;
        e.rs = m_rs[d][t]; e.rt = m_rt[d][t]; e.dim = m_dim[d];
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      logic [15:0] ors, ort, odim;
      e = sb.pop_front();
      ors  = (e.d == 0) ? {8'h00, a_rs[e.t]} : b_rs[e.t];
      ort  = (e.d == 0) ? {8'h00, a_rt[e.t]} : b_rt[e.t];
      odim = (e.d == 0) ? {8'h00, a_dim} : b_dim;
      check($sformatf("%s d%0d t%0d rs", e.tag, e.d, e.t), ors, e.rs);
      check($sformatf("%s d%0d t%0d rt", e.tag, e.d, e.t), ort, e.rt);
      if (e.t == 0) check($sformatf("%s d%0d block_dim", e.tag, e.d), odim, e.dim);
    end
  endtask

  initial begin
    for (int t = 0; t < 4; t++) begin
      a_alu[t] = 8'(8'hA0 + t);
      a_lsu[t] = 8'(8'h10 + t);
    end
    for (int t = 0; t < 8; t++) begin
      b_alu[t] = 16'(16'hA0 + t);
      b_lsu[t] = 16'(16'h10 + t);
    end
    //    tag             rst en disp bid       mask   st      we mux    rs  rt  rd  imm
    cycle("reset",         1, 1, 0, 16'h0000, 8'hFF, UPD,    1, 2'b01, 0,  0,  3,  16'hFFFF);
    cycle("req_special",   0, 1, 0, 16'h0000, 8'hFF, REQ,    0, 2'b00, -3, -1, 0,  16'h0000);
    cycle("dispatch",      0, 1, 1, 16'h002A, 8'h07, IDL,    0, 2'b00, 0,  0,  0,  16'h0000);
    cycle("req_bid_dim",   0, 1, 0, 16'h0000, 8'h07, REQ,    0, 2'b00, -3, -2, 0,  16'h0000);
    cycle("upd_lsu_r5",    0, 1, 0, 16'h0000, 8'h07, UPD,    1, 2'b10, 0,  0,  5,  16'h0000);
    cycle("req_r5",        0, 1, 0, 16'h0000, 8'h07, REQ,    0, 2'b00, 5,  -1, 0,  16'h0000);
    cycle("upd_dim_ro",    0, 1, 0, 16'h0000, 8'hFF, UPD,    1, 2'b01, 0,  0,  -2, 16'hC355);
    cycle("req_dim_r5",    0, 1, 0, 16'h0000, 8'hFF, REQ,    0, 2'b00, -2, 5,  0,  16'h0000);
    cycle("upd_r0",        0, 1, 0, 16'h0000, 8'hFF, UPD,    1, 2'b01, 0,  0,  0,  16'hC355);
    cycle("upd_none_r6",   0, 1, 0, 16'h0000, 8'hFF, UPD,    1, 2'b11, 0,  0,  6,  16'h7777);
    cycle("upd_alu_r7",    0, 1, 0, 16'h0000, 8'hFF, UPD,    1, 2'b00, 0,  0,  7,  16'h0000);
    cycle("upd_we0_r8",    0, 1, 0, 16'h0000, 8'hFF, UPD,    0, 2'b01, 0,  0,  8,  16'h6666);
    cycle("req_r0_r6",     0, 1, 0, 16'h0000, 8'hFF, REQ,    0, 2'b00, 0,  6,  0,  16'h0000);
    cycle("req_r7_r8",     0, 1, 0, 16'h0000, 8'hFF, REQ,    0, 2'b00, 7,  8,  0,  16'h0000);
    cycle("disabled",      0, 0, 1, 16'h1111, 8'hFF, REQ,    0, 2'b00, 5,  -3, 0,  16'h0000);
    cycle("req_after_dis", 0, 1, 0, 16'h0000, 8'hFF, REQ,    0, 2'b00, -3, -2, 0,  16'h0000);
    cycle("disp_req",      0, 1, 1, 16'hB077, 8'hDB, REQ,    0, 2'b00, -3, -2, 0,  16'h0000);
    cycle("req_post_disp", 0, 1, 0, 16'h0000, 8'hFF, REQ,    0, 2'b00, -3, -2, 0,  16'h0000);
    cycle("disp_upd_r9",   0, 1, 1, 16'h0005, 8'hFF, UPD,    1, 2'b01, 0,  0,  9,  16'h9933);
    cycle("req_r9_r5",     0, 1, 0, 16'h0000, 8'hFF, REQ,    0, 2'b00, 9,  5,  0,  16'h0000);
    cycle("other_state",   0, 1, 0, 16'h0000, 8'hFF, 3'b111, 1, 2'b01, 0,  0,  9,  16'h4444);
    cycle("req_r9_tid",    0, 1, 0, 16'h0000, 8'hFF, REQ,    0, 2'b00, 9,  -1, 0,  16'h0000);
    cycle("upd_r3",        0, 1, 0, 16'h0000, 8'hFF, UPD,    1, 2'b01, 0,  0,  3,  16'h1212);
    cycle("rst_upd_r3",    1, 1, 1, 16'h00EE, 8'hFF, UPD,    1, 2'b01, 0,  0,  3,  16'hFFFF);
    cycle("req_r3_dim",    0, 1, 0, 16'h0000, 8'hFF, REQ,    0, 2'b00, 3,  -2, 0,  16'h0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
